// File: rtl/spi_master_seq.sv
// Host-side SPI RAM sequencer: one host request becomes two 10-bit command frames on ss_n/mosi.
// Optional last-address cache when SPI_SEQ_ADDR_CACHE_EN is defined.
module spi_master_seq #(
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {IDLE, SEL, SHIFT, TURN, CAPTURE, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               frame_idx;
  logic               op_rd;
  logic [7:0]         addr_q;
  logic [7:0]         wdata_q;
  logic [8:0]         frame_q;
  logic [6:0]         cap_q;
  logic [9:0]         frame_sel_c;
  logic               hit_c;

  // Frame 0 carries the address, frame 1 the data (or a read-data request)
  always_comb begin
    frame_sel_c = {op_rd, 1'b0, addr_q};
    if (frame_idx) frame_sel_c = op_rd ? {2'b11, 8'h00} : {2'b01, wdata_q};
  end

`ifdef SPI_SEQ_ADDR_CACHE_EN
  logic       wr_vld_q, rd_vld_q;
  logic [7:0] wr_addr_q, rd_addr_q;
  logic       f0_done_c;

  assign f0_done_c = (state == SHIFT) && (cnt == '0) && !frame_idx;
  assign hit_c = req_rd ? (rd_vld_q && (rd_addr_q == req_addr))
                        : (wr_vld_q && (wr_addr_q == req_addr));

  // Remember the address last delivered per op so a repeat can skip frame 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else if (f0_done_c) begin
      if (op_rd) begin
        rd_vld_q  <= 1'b1;
        rd_addr_q <= addr_q;
      end else begin
        wr_vld_q  <= 1'b1;
        wr_addr_q <= addr_q;
      end
    end
  end
`else
  assign hit_c = 1'b0;
`endif

  // Sequencer; ss_n/mosi are registered alongside the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_idx <= 1'b0;
      op_rd     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      frame_q   <= '0;
      cap_q     <= '0;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          ss_n <= 1'b1;
          mosi <= 1'b0;
          if (req_valid && req_ready) begin
            op_rd     <= req_rd;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            frame_idx <= hit_c;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            ss_n      <= 1'b0;
            state     <= SEL;
          end
        end
        SEL: begin
          mosi    <= frame_sel_c[9];
          frame_q <= frame_sel_c[8:0];
          cnt     <= CNT_W'(FRAME_W - 1);
          state   <= SHIFT;
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
            mosi    <= frame_q[8];
            frame_q <= {frame_q[7:0], 1'b0};
          end else begin
            mosi <= 1'b0;
            if (frame_idx && op_rd) begin
              if (RD_LAT == 0) begin
                cnt   <= CNT_W'(DATA_W - 1);
                state <= CAPTURE;
              end else begin
                cnt   <= CNT_W'(RD_LAT - 1);
                state <= TURN;
              end
            end else begin
              ss_n      <= 1'b1;
              rsp_valid <= frame_idx;
              cnt       <= CNT_W'(GAP_CYC - 1);
              state     <= GAP;
            end
          end
        end
        TURN: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(DATA_W - 1);
            state <= CAPTURE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CAPTURE: begin
          cap_q <= {cap_q[5:0], miso};
          if (cnt == '0) begin
            rsp_rdata <= {cap_q, miso};
            rsp_valid <= 1'b1;
            ss_n      <= 1'b1;
            cnt       <= CNT_W'(GAP_CYC - 1);
            state     <= GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (!frame_idx) begin
              frame_idx <= 1'b1;
              ss_n      <= 1'b0;
              state     <= SEL;
            end else begin
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
